// File: rtl/mem_access_stage_if.sv
// Request/acknowledge bus between the MEM stage (master) and a variable-latency data memory (slave).
// Request fields are held stable by the master from request until ack or abort.
interface mem_access_stage_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              memReq;
    logic              memWe;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memAck;
    logic [DATA_W-1:0] memRData;

    modport master (
        output memReq,
        output memWe,
        output memAddr,
        output memWData,
        input  memAck,
        input  memRData
    );

    modport slave (
        input  memReq,
        input  memWe,
        input  memAddr,
        input  memWData,
        output memAck,
        output memRData
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage plus MEM/WB register: issues loads/stores over a req/ack bus and stalls upstream meanwhile.
// Optional MEM_MISALIGN_TRAP_EN: misaligned memory ops are retired without a request and flagged.
module mem_access_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MAX_WAIT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inValid_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  MemToRegIn_i,
    input  logic                  RegWriteIn_i,
    input  logic [REG_ADDR_W-1:0] writeRegIn_i,
    input  logic [DATA_W-1:0]     ALUResultIn_i,
    input  logic [DATA_W-1:0]     storeData_i,
    output logic                  stall_o,
    mem_access_stage_if.master    mem_io,
    output logic                  memErr_o,
    output logic                  outValid_o,
    output logic                  MemToReg_o,
    output logic                  RegWrite_o,
    output logic [REG_ADDR_W-1:0] writeReg_o,
    output logic [DATA_W-1:0]     readData_o,
    output logic [DATA_W-1:0]     ALUResult_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_o
`endif
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e state_q, state_d;

    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  err_q, err_d;

    // Control of the instruction parked in WAIT; its ALU result is addr_q.
    logic                  lat_m2r_q, lat_m2r_d;
    logic                  lat_rw_q, lat_rw_d;
    logic [REG_ADDR_W-1:0] lat_wreg_q, lat_wreg_d;

    logic                  valid_q, valid_d;
    logic                  m2r_q, m2r_d;
    logic                  rw_q, rw_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic                  misal_q, misal_d;

    logic mem_op;
    logic misaligned;
    logic issue;
    logic acked;
    logic timeout;

    assign mem_op = inValid_i & (MemRead_i | MemWrite_i);
`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = mem_op & (ALUResultIn_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign issue   = mem_op & ~misaligned;
    assign acked   = (state_q == StWait) & mem_io.memAck;
    assign timeout = (state_q == StWait) & ~mem_io.memAck & (cnt_q == MaxCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (issue) state_d = StWait;
            StWait: if (acked || timeout) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A timed-out op retires on the next edge like an acked one, so upstream may advance.
    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            StIdle: stall_o = issue;
            StWait: stall_o = ~mem_io.memAck & ~timeout;
            default: stall_o = 1'b0;
        endcase
        stall_o = stall_o & rst_n;
    end

    always_comb begin
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        lat_m2r_d  = lat_m2r_q;
        lat_rw_d   = lat_rw_q;
        lat_wreg_d = lat_wreg_q;
        // MEM/WB defaults to a bubble.
        valid_d    = 1'b0;
        rw_d       = 1'b0;
        rdata_d    = '0;
        m2r_d      = m2r_q;
        wreg_d     = wreg_q;
        alu_d      = alu_q;
        misal_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    req_d      = 1'b1;
                    we_d       = MemWrite_i;
                    addr_d     = ALUResultIn_i;
                    wdata_d    = storeData_i;
                    cnt_d      = '0;
                    lat_m2r_d  = MemToRegIn_i;
                    lat_rw_d   = RegWriteIn_i;
                    lat_wreg_d = writeRegIn_i;
                end else begin
                    valid_d = inValid_i;
                    rw_d    = inValid_i & RegWriteIn_i & ~misaligned;
                    m2r_d   = MemToRegIn_i;
                    wreg_d  = writeRegIn_i;
                    alu_d   = ALUResultIn_i;
                    misal_d = misaligned;
                end
            end
            StWait: begin
                if (acked || timeout) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    m2r_d   = lat_m2r_q;
                    wreg_d  = lat_wreg_q;
                    alu_d   = addr_q;
                    if (acked) begin
                        rw_d    = lat_rw_q;
                        rdata_d = we_q ? '0 : mem_io.memRData;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            lat_m2r_q  <= 1'b0;
            lat_rw_q   <= 1'b0;
            lat_wreg_q <= '0;
            valid_q    <= 1'b0;
            m2r_q      <= 1'b0;
            rw_q       <= 1'b0;
            wreg_q     <= '0;
            rdata_q    <= '0;
            alu_q      <= '0;
            misal_q    <= 1'b0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            lat_m2r_q  <= lat_m2r_d;
            lat_rw_q   <= lat_rw_d;
            lat_wreg_q <= lat_wreg_d;
            valid_q    <= valid_d;
            m2r_q      <= m2r_d;
            rw_q       <= rw_d;
            wreg_q     <= wreg_d;
            rdata_q    <= rdata_d;
            alu_q      <= alu_d;
            misal_q    <= misal_d;
        end
    end

    assign mem_io.memReq   = req_q;
    assign mem_io.memWe    = we_q;
    assign mem_io.memAddr  = addr_q;
    assign mem_io.memWData = wdata_q;

    assign memErr_o    = err_q;
    assign outValid_o  = valid_q;
    assign MemToReg_o  = m2r_q;
    assign RegWrite_o  = rw_q & valid_q;
    assign writeReg_o  = wreg_q;
    assign readData_o  = rdata_q;
    assign ALUResult_o = alu_q;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o = misal_q;
`else
    logic unused_misal;
    assign unused_misal = misal_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized ops checked against
// a transaction-level model (stall count, retire values) derived from the stage's rules.
module tb_mem_access_stage;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, mem_read, mem_write, m2r_in, rw_in;
    logic [4:0]  wreg_in;
    logic [31:0] alu_in, sdata_in;
    logic        stall, mem_err, out_valid, mem_to_reg, reg_write;
    logic [4:0]  write_reg;
    logic [31:0] read_data, alu_result;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;

    mem_access_stage_if #(.DATA_W(32)) bus ();

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W    (32),
        .REG_ADDR_W(5),
        .MAX_WAIT  (MW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inValid_i    (in_valid),
        .MemRead_i    (mem_read),
        .MemWrite_i   (mem_write),
        .MemToRegIn_i (m2r_in),
        .RegWriteIn_i (rw_in),
        .writeRegIn_i (wreg_in),
        .ALUResultIn_i(alu_in),
        .storeData_i  (sdata_in),
        .stall_o      (stall),
        .mem_io       (bus),
        .memErr_o     (mem_err),
        .outValid_o   (out_valid),
        .MemToReg_o   (mem_to_reg),
        .RegWrite_o   (reg_write),
        .writeReg_o   (write_reg),
        .readData_o   (read_data),
        .ALUResult_o  (alu_result)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Presents one instruction, answers with memAck d cycles after memReq rises (never if d > MW),
    // and checks every cycle until it appears in MEM/WB.
    task automatic run_op(input logic v, input logic rd, input logic wr, input logic m2r,
                          input logic rw, input logic [4:0] wrg, input logic [31:0] alu,
                          input logic [31:0] sd, input int d, input logic [31:0] rdat);
        logic mem_op, mis, issue, timed;
        int   s;
        mem_op = v & (rd | wr);
        mis    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = mem_op && (alu[1:0] != 2'b00);
`endif
        issue = mem_op && !mis;
        timed = issue && (d > MW);
        s     = issue ? 1 + ((d > MW) ? MW : d) : 0;

        @(posedge clk);
        #1;
        in_valid  = v;
        mem_read  = rd;
        mem_write = wr;
        m2r_in    = m2r;
        rw_in     = rw;
        wreg_in   = wrg;
        alu_in    = alu;
        sdata_in  = sd;
        for (int k = 0; k <= s; k++) begin
            bus.memAck   = (k == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.memRData = $urandom;
            if (issue && k >= 1 && (k - 1) == d) begin
                bus.memAck   = 1'b1;
                bus.memRData = rdat;
            end
            @(negedge clk);
            check("stall", 32'(stall), 32'(k < s));
            check("memErr_idle", 32'(mem_err), 32'h0);
            if (k >= 1) begin
                check("memReq", 32'(bus.memReq), 32'h1);
                check("memWe", 32'(bus.memWe), 32'(wr));
                check("memAddr", bus.memAddr, alu);
                check("memWData", bus.memWData, sd);
                check("bubble_valid", 32'(out_valid), 32'h0);
                check("bubble_regwrite", 32'(reg_write), 32'h0);
            end
            @(posedge clk);
            #1;
        end
        in_valid     = 1'b0;
        bus.memAck   = 1'b0;
        @(negedge clk);
        check("outValid", 32'(out_valid), 32'(v));
        check("RegWrite", 32'(reg_write), 32'(v & rw & !timed & !mis));
        check("readData", read_data, (issue && !timed && rd && !wr) ? rdat : 32'h0);
        check("memErr", 32'(mem_err), 32'(timed));
        check("memReq_done", 32'(bus.memReq), 32'h0);
        if (v) begin
            check("ALUResult", alu_result, alu);
            check("writeReg", 32'(write_reg), 32'(wrg));
            check("MemToReg", 32'(mem_to_reg), 32'(m2r));
        end
`ifdef MEM_MISALIGN_TRAP_EN
        check("misalign", 32'(misalign), 32'(mis));
`endif
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        m2r_in       = 1'b0;
        rw_in        = 1'b0;
        wreg_in      = '0;
        alu_in       = '0;
        sdata_in     = '0;
        bus.memAck   = 1'b0;
        bus.memRData = '0;
        #12;
        check("rst_memReq", 32'(bus.memReq), 32'h0);
        check("rst_memWe", 32'(bus.memWe), 32'h0);
        check("rst_memAddr", bus.memAddr, 32'h0);
        check("rst_memWData", bus.memWData, 32'h0);
        check("rst_memErr", 32'(mem_err), 32'h0);
        check("rst_outValid", 32'(out_valid), 32'h0);
        check("rst_RegWrite", 32'(reg_write), 32'h0);
        check("rst_readData", read_data, 32'h0);
        check("rst_ALUResult", alu_result, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        rst_n = 1'b1;

        // ALU op, load with 3-cycle ack, store acked on first WAIT cycle.
        run_op(1, 0, 0, 0, 1, 5'd8, 32'h2A, 32'h0, 0, 32'h0);
        run_op(1, 1, 0, 1, 1, 5'd9, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        run_op(1, 0, 1, 0, 0, 5'd0, 32'h104, 32'h55, 0, 32'h0);

        // Timeout, then a late ack in IDLE must be ignored.
        run_op(1, 1, 0, 1, 1, 5'd3, 32'h200, 32'h0, MW + 3, 32'h0);
        @(posedge clk);
        #1;
        bus.memAck   = 1'b1;
        bus.memRData = 32'hBAD0BAD0;
        @(negedge clk);
        check("late_ack_stall", 32'(stall), 32'h0);
        check("late_ack_req", 32'(bus.memReq), 32'h0);
        @(posedge clk);
        #1;
        bus.memAck = 1'b0;
        @(negedge clk);
        check("late_ack_valid", 32'(out_valid), 32'h0);
        check("late_ack_err", 32'(mem_err), 32'h0);

        // Reset while waiting on memory.
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        rw_in     = 1'b1;
        alu_in    = 32'h300;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_memReq", 32'(bus.memReq), 32'h0);
        check("midrst_outValid", 32'(out_valid), 32'h0);
        check("midrst_stall", 32'(stall), 32'h0);
        check("midrst_RegWrite", 32'(reg_write), 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, 1, 0, 1, 1, 5'd4, 32'h300, 32'h0, 1, 32'h12345678);

        // Misaligned load: trapped or issued depending on build.
        run_op(1, 1, 0, 1, 1, 5'd7, 32'h102, 32'h0, 1, 32'hCAFEF00D);

        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 5'($urandom), $urandom, $urandom, int'($urandom_range(0, MW + 2)),
                   $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
